// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL control and pixel-domain reset bundle
//
// Purpose: groups the PLL handshake and the pixel-domain reset/status lines.
// Ports (signals):
//   locked      - PLL LOCK, asynchronous to clock_in
//   restart     - synchronous request to re-run the sequence
//   pll_resetb  - PLL RESETB, low holds the PLL in reset
//   pll_bypass  - PLL BYPASS
//   sys_reset   - active-high pixel-domain reset
//   ready       - sequence complete, PLL running
//   fault       - retries exhausted
//   lock_lost   - one-cycle pulse on lock loss while running
//   retry_count - failed attempts in the current sequence
// Modports: master = sequencer side, slave = PLL/consumer side.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_count;

  modport master (
    input  locked, restart,
    output pll_resetb, pll_bypass, sys_reset, ready, fault, lock_lost, retry_count
  );

  modport slave (
    output locked, restart,
    input  pll_resetb, pll_bypass, sys_reset, ready, fault, lock_lost, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - iCE40 PLL bring-up and pixel-domain reset sequencer
//
// Purpose: holds the PLL in reset, waits for lock, requires lock to stay
// stable before releasing the pixel-domain reset, retries on timeout or
// chatter and parks in FAULT once retries are exhausted.
// Ports:
//   clock_in - 12 MHz reference clock, rising edge
//   reset    - asynchronous active-high reset
//   bus      - pll_reset_sequencer_if.master (locked/restart in, status out)
// Optional feature: PLL_RESET_SEQUENCER_BYPASS_FALLBACK_EN - in FAULT run the
// pixel domain from the reference clock through PLL bypass.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 12000,
  parameter int unsigned STABLE_CYCLES = 1200,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input logic                    clock_in,
  input logic                    reset,
  pll_reset_sequencer_if.master  bus
);

  localparam int unsigned MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          fail;
  logic          resetb_q, resetb_d;
  logic          sys_reset_q, sys_reset_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          lock_lost_q, lock_lost_d;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    fail        = 1'b0;

    if (bus.restart) begin
      // Restart outranks every lock, timeout and failure event this cycle.
      state_d = ST_PLL_RESET;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_PLL_RESET: if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still wins.
          if (lock_s)                  state_d = ST_STABLE;
          else if (cnt_q == LOCK_LAST) fail = 1'b1;
        end
        ST_STABLE: begin
          if (!lock_s)                   fail = 1'b1;
          else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Lock loss starts a fresh sequence rather than counting as a failure.
          if (!lock_s) begin
            state_d     = ST_PLL_RESET;
            retry_d     = 4'd0;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_PLL_RESET;
      endcase

      if (fail) begin
        if (retry_q == RETRY_MAX) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_PLL_RESET;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end
      end
    end

    if (bus.restart || (state_d != state_q))
      cnt_d = '0;
    else if (state_q == ST_PLL_RESET || state_q == ST_WAIT_LOCK || state_q == ST_STABLE)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;

    // Outputs are decoded from the state being entered so they register on the same edge.
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
    sys_reset_d = (state_d != ST_RUN);
`ifdef PLL_RESET_SEQUENCER_BYPASS_FALLBACK_EN
    resetb_d    = (state_d != ST_PLL_RESET);
    // Pixel domain released one cycle after FAULT is entered, clocked via bypass.
    if (state_q == ST_FAULT && state_d == ST_FAULT)
      sys_reset_d = 1'b0;
`else
    resetb_d    = (state_d != ST_PLL_RESET) && (state_d != ST_FAULT);
`endif
  end

`ifdef PLL_RESET_SEQUENCER_BYPASS_FALLBACK_EN
  logic bypass_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) bypass_q <= 1'b0;
    else       bypass_q <= (state_d == ST_FAULT);
  end

  assign bus.pll_bypass = bypass_q;
`else
  assign bus.pll_bypass = 1'b0;
`endif

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      sync_q      <= 2'b00;
      resetb_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= {sync_q[0], bus.locked};
      resetb_q    <= resetb_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.pll_resetb  = resetb_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.ready       = ready_q;
  assign bus.fault       = fault_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
  localparam int R = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int M = 2;
`ifdef PLL_RESET_SEQUENCER_BYPASS_FALLBACK_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RESET_CYCLES (R),
    .LOCK_TIMEOUT (T),
    .STABLE_CYCLES(S),
    .MAX_RETRIES  (M)
  ) dut (
    .clock_in(clock_in),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus cycles spent in it, lock seen two edges late.
  int m_phase = PH_RST;
  int m_age   = 0;
  int m_tries = 0;
  bit m_lost  = 1'b0;
  bit m_h0    = 1'b0;
  bit m_h1    = 1'b0;

  always @(posedge clock_in) begin
    bit ls, fl;
    if (reset) begin
      m_phase = PH_RST; m_age = 0; m_tries = 0; m_lost = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
    end else begin
      ls = m_h1; fl = 1'b0; m_lost = 1'b0;
      if (bus.restart) begin
        m_phase = PH_RST; m_age = 0; m_tries = 0;
      end else begin
        case (m_phase)
          PH_RST: begin
            m_age++;
            if (m_age == R) begin m_phase = PH_WAIT; m_age = 0; end
          end
          PH_WAIT: begin
            if (ls) begin m_phase = PH_STAB; m_age = 0; end
            else begin m_age++; if (m_age == T) fl = 1'b1; end
          end
          PH_STAB: begin
            if (!ls) fl = 1'b1;
            else begin m_age++; if (m_age == S) begin m_phase = PH_RUN; m_age = 0; end end
          end
          PH_RUN: begin
            if (!ls) begin m_phase = PH_RST; m_age = 0; m_tries = 0; m_lost = 1'b1; end
          end
          default: m_age++;
        endcase
        if (fl) begin
          m_age = 0;
          if (m_tries == M) m_phase = PH_FAULT;
          else begin m_tries++; m_phase = PH_RST; end
        end
      end
      m_h1 = m_h0;
      m_h0 = bus.locked;
    end
    #1;
    chk("model_pll_resetb", bus.pll_resetb,
        (m_phase == PH_RST) ? 1'b0 : (m_phase == PH_FAULT) ? BYP : 1'b1);
    chk("model_pll_bypass", bus.pll_bypass, BYP && (m_phase == PH_FAULT));
    chk("model_sys_reset", bus.sys_reset,
        !((m_phase == PH_RUN) || (BYP && m_phase == PH_FAULT && m_age >= 1)));
    chk("model_ready", bus.ready, m_phase == PH_RUN);
    chk("model_fault", bus.fault, m_phase == PH_FAULT);
    chk("model_lock_lost", bus.lock_lost, m_lost);
    chk("model_retry_count", bus.retry_count, 16'(m_tries));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, lows, seen;
    bit rdy;
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clock_in);
    chk("rst_pll_resetb", bus.pll_resetb, 1'b0);
    chk("rst_sys_reset", bus.sys_reset, 1'b1);
    chk("rst_retry", bus.retry_count, 4'd0);
    reset = 1'b0;

    // Nominal bring-up
    n = 0;
    while (bus.pll_resetb === 1'b0 && n < 50) begin n++; @(negedge clock_in); end
    chk("t1_resetb_low_cycles", 16'(n), 16'd4);
    repeat (3) @(negedge clock_in);
    bus.locked = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clock_in); k++;
      if (bus.ready === 1'b1) break;
    end
    chk("t1_ready_edges", 16'(k), 16'd11);
    chk("t1_sys_reset", bus.sys_reset, 1'b0);
    chk("t1_retry", bus.retry_count, 4'd0);
    repeat (5) @(negedge clock_in);

    // Lock loss in RUN
    bus.locked = 1'b0;
    k = 0;
    while (k < 10) begin
      @(negedge clock_in); k++;
      if (bus.lock_lost === 1'b1) break;
    end
    chk("t4_lost_edges", 16'(k), 16'd3);
    chk("t4_sys_reset", bus.sys_reset, 1'b1);
    chk("t4_ready", bus.ready, 1'b0);
    chk("t4_retry", bus.retry_count, 4'd0);
    chk("t4_resetb", bus.pll_resetb, 1'b0);
    @(negedge clock_in);
    chk("t4_lost_pulse_end", bus.lock_lost, 1'b0);

    // Timeout retries into FAULT
    bus.restart = 1'b1;
    @(negedge clock_in);
    bus.restart = 1'b0;
    k = 1; lows = 0; seen = 0;
    while (bus.fault !== 1'b1 && k < 200) begin
      if (bus.pll_resetb === 1'b0) lows++;
      seen = seen | (1 << bus.retry_count);
      @(negedge clock_in); k++;
    end
    chk("t2_edges_to_fault", 16'(k), 16'd73);
    chk("t2_low_cycles", 16'(lows), 16'd12);
    chk("t2_retry_seen", 16'(seen), 16'd7);
    chk("t2_retry_at_fault", bus.retry_count, 4'd2);
    repeat (2) @(negedge clock_in);
    chk("t6_fault_bypass", bus.pll_bypass, BYP);
    chk("t6_fault_sys_reset", bus.sys_reset, !BYP);
    chk("t6_fault_resetb", bus.pll_resetb, BYP);
    bus.locked = 1'b1;
    repeat (5) @(negedge clock_in);
    chk("t2_fault_holds", bus.fault, 1'b1);
    chk("t2_fault_no_ready", bus.ready, 1'b0);
    bus.locked = 1'b0;

    // Restart from FAULT
    bus.restart = 1'b1;
    @(negedge clock_in);
    bus.restart = 1'b0;
    chk("t5a_fault", bus.fault, 1'b0);
    chk("t5a_retry", bus.retry_count, 4'd0);
    chk("t5a_resetb", bus.pll_resetb, 1'b0);
    chk("t5a_bypass", bus.pll_bypass, 1'b0);

    // Restart on the WAIT_LOCK timeout cycle
    repeat (23) @(negedge clock_in);
    chk("t5b_pre_resetb", bus.pll_resetb, 1'b1);
    bus.restart = 1'b1;
    @(negedge clock_in);
    bus.restart = 1'b0;
    chk("t5b_retry", bus.retry_count, 4'd0);
    chk("t5b_resetb", bus.pll_resetb, 1'b0);
    chk("t5b_fault", bus.fault, 1'b0);
    n = 0;
    while (bus.pll_resetb === 1'b0 && n < 20) begin n++; @(negedge clock_in); end
    chk("t5b_low_cycles", 16'(n), 16'd4);

    // Lock chatter in STABLE
    bus.locked = 1'b1;
    rdy = 1'b0;
    repeat (6) begin @(negedge clock_in); rdy = rdy | bus.ready; end
    bus.locked = 1'b0;
    @(negedge clock_in); rdy = rdy | bus.ready;
    bus.locked = 1'b1;
    repeat (2) begin @(negedge clock_in); rdy = rdy | bus.ready; end
    chk("t3_no_ready", rdy, 1'b0);
    chk("t3_retry", bus.retry_count, 4'd1);
    chk("t3_resetb", bus.pll_resetb, 1'b0);
    n = 0;
    while (bus.pll_resetb === 1'b0 && n < 20) begin n++; @(negedge clock_in); end
    chk("t3_low_cycles", 16'(n), 16'd4);

    // Asynchronous reset mid-STABLE
    repeat (4) @(negedge clock_in);
    chk("t6_pre_resetb", bus.pll_resetb, 1'b1);
    chk("t6_pre_retry", bus.retry_count, 4'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_resetb", bus.pll_resetb, 1'b0);
    chk("t6_async_sys_reset", bus.sys_reset, 1'b1);
    chk("t6_async_retry", bus.retry_count, 4'd0);
    chk("t6_async_ready", bus.ready, 1'b0);
    chk("t6_async_fault", bus.fault, 1'b0);
    chk("t6_async_bypass", bus.pll_bypass, 1'b0);
    @(negedge clock_in);
    reset = 1'b0;
    repeat (40) @(negedge clock_in);
    chk("t6_rerun_ready", bus.ready, 1'b1);
    chk("t6_rerun_retry", bus.retry_count, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
